// File: rtl/motion_arbiter.sv
// Motion-command arbiter: selects a control source from the mode byte and drives the
// motor controller with obstacle override, dead-time on reversal and optional soft start (MOTION_RAMP_EN).
module motion_arbiter #(
  parameter int unsigned PWM_RUN     = 128,
  parameter int unsigned DIST_THRESH = 200,
  parameter int unsigned DEAD_CYCLES = 50000,
  parameter int unsigned RAMP_DIV    = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  cmd,
  input  logic [15:0] distance,
  input  logic        distance_valid,
  input  logic [3:0]  track,
  input  logic [1:0]  light,
  input  logic [3:0]  signal,
  output logic [3:0]  mode,
  output logic [7:0]  pwm,
  output logic [3:0]  led,
  output logic        dead
);

  typedef enum logic [2:0] {SRC_NONE, SRC_AVOID, SRC_TRACK, SRC_REMOTE, SRC_LIGHT} source_e;
  typedef enum logic [1:0] {ST_STOP, ST_DRIVE, ST_DEAD} state_e;

  typedef struct packed {
    logic [7:0]  cmd;
    logic [15:0] distance;
    logic        dv;
    logic [1:0]  track;   // {track[2], track[1]}
    logic [1:0]  light;
    logic [3:0]  signal;
  } in_t;

  localparam logic [3:0] M_STOP  = 4'd0;
  localparam logic [3:0] M_BACK  = 4'd1;
  localparam logic [3:0] M_FWD   = 4'd2;
  localparam logic [3:0] M_RIGHT = 4'd3;
  localparam logic [3:0] M_LEFT  = 4'd4;

  localparam int unsigned    DW        = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [DW-1:0]  DEAD_LOAD = DW'(DEAD_CYCLES - 1);
  localparam logic [15:0]    DIST_TH   = 16'(DIST_THRESH);
  localparam logic [7:0]     PWM_MAX   = 8'(PWM_RUN);
`ifdef MOTION_RAMP_EN
  localparam int unsigned    RW        = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [RW-1:0]  RAMP_LAST = RW'(RAMP_DIV - 1);
  localparam logic [7:0]     PWM_START = 8'd0;
`else
  localparam logic [7:0]     PWM_START = PWM_MAX;
`endif

  in_t     in_s1_q, in_s2_q;
  source_e src_q, src_d;
  logic [3:0] led_q, led_d;
  logic    obst_q, obst_d;
  logic [3:0] req_raw, req;

  state_e  state_q, state_d;
  logic [3:0]    dir_q, dir_d;
  logic [DW-1:0] dead_cnt_q, dead_cnt_d;
  logic [7:0]    pwm_q, pwm_d;
`ifdef MOTION_RAMP_EN
  logic [RW-1:0] ramp_cnt_q, ramp_cnt_d;
`endif

  // Line sensors 0 and 3 are not wired to any decision.
  logic unused_track;
  assign unused_track = ^{track[3], track[0]};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_s1_q <= '0;
      in_s2_q <= '0;
    end else begin
      in_s1_q <= '{cmd: cmd, distance: distance, dv: distance_valid,
                   track: {track[2], track[1]}, light: light, signal: signal};
      in_s2_q <= in_s1_q;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    src_d = SRC_NONE;
    led_d = 4'b1111;
    unique case (in_s2_q.cmd)
      8'hFE:   begin src_d = SRC_AVOID;  led_d = 4'b0001; end
      8'hF8:   begin src_d = SRC_TRACK;  led_d = 4'b0011; end
      8'hE0:   begin src_d = SRC_REMOTE; led_d = 4'b0111; end
      8'h80:   begin src_d = SRC_LIGHT;  led_d = 4'b1111; end
      default: begin src_d = SRC_NONE;   led_d = 4'b1111; end
    endcase
    obst_d = in_s2_q.dv ? (in_s2_q.distance <= DIST_TH) : obst_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_q  <= SRC_NONE;
      led_q  <= 4'b0000;
      obst_q <= 1'b0;
    end else begin
      src_q  <= src_d;
      led_q  <= led_d;
      obst_q <= obst_d;
    end
  end

  // Per-source motion request; track order is {track[1], track[2]}.
  always_comb begin
    req_raw = M_STOP;
    unique case (src_q)
      SRC_AVOID: req_raw = obst_q ? M_BACK : M_FWD;
      SRC_TRACK:
        unique case ({in_s2_q.track[0], in_s2_q.track[1]})
          2'b11:   req_raw = M_FWD;
          2'b01:   req_raw = M_LEFT;
          2'b10:   req_raw = M_RIGHT;
          default: req_raw = M_STOP;
        endcase
      SRC_LIGHT:
        unique case (in_s2_q.light)
          2'b11:   req_raw = M_FWD;
          2'b10:   req_raw = M_LEFT;
          2'b01:   req_raw = M_RIGHT;
          default: req_raw = M_STOP;
        endcase
      SRC_REMOTE:
        unique case (in_s2_q.signal)
          4'b0001: req_raw = M_FWD;
          4'b0010: req_raw = M_BACK;
          4'b0100: req_raw = M_RIGHT;
          4'b1000: req_raw = M_LEFT;
          default: req_raw = M_STOP;
        endcase
      default: req_raw = M_STOP;
    endcase
    req = (req_raw == M_FWD && obst_q) ? M_STOP : req_raw;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_STOP;
      dir_q      <= M_STOP;
      dead_cnt_q <= '0;
      pwm_q      <= 8'd0;
`ifdef MOTION_RAMP_EN
      ramp_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      dead_cnt_q <= dead_cnt_d;
      pwm_q      <= pwm_d;
`ifdef MOTION_RAMP_EN
      ramp_cnt_q <= ramp_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    dead_cnt_d = dead_cnt_q;
    pwm_d      = pwm_q;
`ifdef MOTION_RAMP_EN
    ramp_cnt_d = ramp_cnt_q;
`endif
    unique case (state_q)
      ST_STOP:
        if (req != M_STOP) begin
          state_d = ST_DRIVE;
          dir_d   = req;
          pwm_d   = PWM_START;
`ifdef MOTION_RAMP_EN
          ramp_cnt_d = '0;
`endif
        end
      ST_DRIVE:
        if (req == M_STOP) begin
          state_d = ST_STOP;
        end else if (req != dir_q) begin
          state_d    = ST_DEAD;
          dead_cnt_d = DEAD_LOAD;
        end else begin
`ifdef MOTION_RAMP_EN
          if (pwm_q < PWM_MAX) begin
            if (ramp_cnt_q == RAMP_LAST) begin
              ramp_cnt_d = '0;
              pwm_d      = pwm_q + 8'd1;
            end else begin
              ramp_cnt_d = ramp_cnt_q + RW'(1);
            end
          end
`endif
        end
      ST_DEAD:
        // The exit decision uses whatever request is present when the count expires.
        if (dead_cnt_q != '0) begin
          dead_cnt_d = dead_cnt_q - DW'(1);
        end else if (req == M_STOP) begin
          state_d = ST_STOP;
        end else begin
          state_d = ST_DRIVE;
          dir_d   = req;
          pwm_d   = PWM_START;
`ifdef MOTION_RAMP_EN
          ramp_cnt_d = '0;
`endif
        end
      default: state_d = ST_STOP;
    endcase
  end

  always_comb begin
    mode = (state_q == ST_DRIVE) ? dir_q : M_STOP;
    pwm  = (state_q == ST_DRIVE) ? pwm_q : 8'd0;
    dead = (state_q == ST_DEAD);
    led  = led_q;
  end

endmodule

// File: doc/motion_arbiter.md
# motion_arbiter

Motion-command arbiter for the four-wheel car. Decodes the Bluetooth mode byte into an active control source (obstacle avoidance, line tracking, remote, light following), computes that source's motion request from its sensors, and drives the motor controller's `mode`/`pwm` inputs. It sits between the UART receiver, the ultrasonic ranger and the sensor pins on one side and `Four_Wheel_Control` on the other. It enforces three rules:
- forward motion is blocked whenever an obstacle is close;
- every direction change passes through a dead-time stop;
- PWM is soft-started.

## Interface
Parameters:
- `PWM_RUN`, 128: cruise duty (0–255).
- `DIST_THRESH`, 200: obstacle threshold, same units as `distance`.
- `DEAD_CYCLES`, 50000: stop cycles inserted on a direction change (≥1).
- `RAMP_DIV`, 1000: clocks per +1 PWM step during soft start (≥1).

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `cmd`  in  8  mode byte from the UART receiver (level, held).
- `distance`  in  16  ultrasonic distance.
- `distance_valid`  in  1  one-cycle strobe, `distance` valid.
- `track`  in  4  line sensors (bits 1, 2 used), asynchronous.
- `light`  in  2  light sensors, asynchronous.
- `signal`  in  4  remote keys, asynchronous.
- `mode`  out  4  motor command: 0 stop, 1 back, 2 forward, 3 right, 4 left.
- `pwm`  out  8  motor duty.
- `led`  out  4  source indicator.
- `dead`  out  1  high while in dead time.

## Operation
**Input registration**
- All inputs pass through a two-flop stage: synchronizer for the asynchronous pins, plain delay for the others.
- Logic below uses only the registered copies.

**Source register** (from registered `cmd`):
- 0xFE: AVOID, `led`=0001.
- 0xF8: TRACK, `led`=0011.
- 0xE0: REMOTE, `led`=0111.
- 0x80: LIGHT, `led`=1111.
- Any other value: NONE, `led`=1111.

**Obstacle flag**
- Updated only on a registered `distance_valid`: set to (`distance` ≤ `DIST_THRESH`).
- Otherwise held.

**Request by source**
- AVOID: obstacle → 1, else 2.
- TRACK, using `track[1]`,`track[2]`: 11 → 2; 01 → 4; 10 → 3; 00 → 0.
- LIGHT, using `light[1]`,`light[0]`: 11 → 2; 10 → 4; 01 → 3; 00 → 0.
- REMOTE, using `signal`: 0001 → 2; 0010 → 1; 0100 → 3; 1000 → 4; any other (including multi-key) → 0.
- NONE: 0.
- Safety override for every source: request 2 with obstacle set becomes 0.

**FSM**
- STOP: `mode`=0, `pwm`=0.
  - Request ≠ 0 → DRIVE with `mode`=request and `pwm`=0; ramp starts.
- DRIVE:
  - Request equals current `mode` → stay; ramp `pwm` by +1 every `RAMP_DIV` clocks, saturating at `PWM_RUN`.
  - Request = 0 → STOP.
  - Request ≠ 0 and ≠ current → DEAD.
- DEAD: `mode`=0, `pwm`=0, `dead`=1; counter loads `DEAD_CYCLES`−1.
  - Counter decrements each clock. At 0, the request sampled in that cycle decides the next state: 0 → STOP, else DRIVE with the ramp restarted from 0.
  - Request changes during DEAD do not restart the counter.
- Source change does not bypass the FSM: a new source's request is handled as an ordinary request change.

## Timing
- Reset (asynchronous, any time, including mid-DEAD or mid-ramp) gives: `mode`=0, `pwm`=0, `led`=0000, `dead`=0, STOP, source NONE, obstacle flag 0, counters 0.
- Sensor change to `mode` change: 3 rising edges from STOP (2 sync + 1 FSM).
- `cmd` change: source/`led` at edge 3, `mode` at edge 4.
- Direction change while DRIVE: `mode`=0 on the edge after the request is seen; new `mode` exactly `DEAD_CYCLES` clocks later.
- Ramp: `pwm` reaches `PWM_RUN` after `PWM_RUN`×`RAMP_DIV` clocks in DRIVE.
- `pwm` is 0 in every cycle where `mode`=0.
- `distance_valid` during reset is lost; the flag is 0 until the next strobe.

## Configuration
- `MOTION_RAMP_EN` defined: soft-start ramp as above.
- `MOTION_RAMP_EN` undefined:
  - `pwm`=`PWM_RUN` on the same edge DRIVE is entered.
  - The ramp counter is removed.
  - `RAMP_DIV` is ignored.
- Dead time and the obstacle override are always present.

## Test plan
Bench settings: `DEAD_CYCLES`=4, `RAMP_DIV`=2, `PWM_RUN`=8.
- Reset asserted mid-ramp in TRACK → next cycle `mode`=0, `pwm`=0, `led`=0000; after release with `cmd`=0xF8 and `track[2:1]`=11 → `led`=0011 at edge 3, `mode`=2 at edge 4, `pwm` 0→8 in 16 clocks.
- REMOTE, `signal`=0001, then 0010 → `mode` 2 → 0 with `dead`=1 for 4 clocks → 1, ramp restarts from 0; `signal`=0011 → `mode`=0 with no DEAD state.
- AVOID, strobe `distance`=300 → `mode`=2; strobe 200 → `mode` goes 0 for 4 clocks then 1; strobe 201 → 0 for 4 clocks then 2.
- LIGHT, `light`=11 driving, `distance`=100 strobed → `mode`=0 (override); `light`=01 → DRIVE with `mode`=3 (from STOP, no dead time).
- DEAD active, request toggles 3→4→3 inside the window → counter not restarted; exits after 4 clocks to `mode`=3.
- `cmd`=0x55 while driving → `led`=1111, `mode`=0, `pwm`=0; build without `MOTION_RAMP_EN` → `pwm`=8 on DRIVE entry.
